belief_update: RTL and testbench

BELIEF_UPDATE -- requirements
Module: belief_update

---
 rtl/pomdp_pkg.sv | 23 ++
 rtl/udiv_q16.sv | 72 +++++++
 rtl/belief_update.sv | 126 ++++++++++++
 tb/tb_belief_update.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pomdp_pkg.sv
// Shared types and sizes for the two-state POMDP belief updater.
// Probabilities are unsigned Q0.16; 16'hFFFF stands in for 1.0.
package pomdp_pkg;

  localparam int PROB_W  = 16;
  localparam int N_ACT   = 3;
  localparam int N_STATE = 2;
  localparam int N_OBS   = 2;

  typedef logic [PROB_W-1:0] prob_t;

  typedef enum logic [2:0] {
    IDLE,
    PREDICT,
    WEIGHT,
    DIVIDE,
    DONE
  } state_t;

  localparam prob_t PROB_ONE = 16'hFFFF;
  localparam prob_t B0_RST   = 16'h8000;

endpackage

// File: rtl/udiv_q16.sv
// Fixed-latency restoring divider: quotient = floor(dividend / divisor) over 16 iterations.
// Saturates to 16'hFFFF when dividend[31:16] >= divisor; a zero divisor is flagged instead.
module udiv_q16
  import pomdp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [16:0] divisor,
  output logic        done,
  output prob_t       quotient,
  output logic        div_zero
);

  logic [16:0] rem_r;
  logic [16:0] div_r;
  logic [16:0] rem_sub;
  logic [16:0] rem_nxt;
  logic [17:0] rem_sh;
  logic [15:0] lo_r;
  logic [15:0] q_r;
  logic [3:0]  cnt_r;
  logic        busy_r;
  logic        ovf_r;
  logic        dz_r;
  logic        take;

  // The remainder stays below the divisor, so 17 bits hold it between iterations.
  always_comb begin
    rem_sh  = {rem_r, lo_r[15]};
    take    = (rem_sh >= {1'b0, div_r});
    rem_sub = rem_sh[16:0] - div_r;
    rem_nxt = take ? rem_sub : rem_sh[16:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_r  <= '0;
      div_r  <= '0;
      lo_r   <= '0;
      q_r    <= '0;
      cnt_r  <= '0;
      busy_r <= 1'b0;
      ovf_r  <= 1'b0;
      dz_r   <= 1'b0;
    end else if (start) begin
      rem_r  <= {1'b0, dividend[31:16]};
      lo_r   <= dividend[15:0];
      div_r  <= divisor;
      q_r    <= '0;
      cnt_r  <= '0;
      busy_r <= 1'b1;
      ovf_r  <= ({1'b0, dividend[31:16]} >= divisor);
      dz_r   <= (divisor == 17'd0);
    end else if (busy_r) begin
      rem_r  <= rem_nxt;
      lo_r   <= {lo_r[14:0], 1'b0};
      q_r    <= {q_r[14:0], take};
      cnt_r  <= cnt_r + 4'd1;
      if (cnt_r == 4'd15)
        busy_r <= 1'b0;
    end
  end

  // done marks the cycle whose closing edge performs the last iteration;
  // quotient is final from the following cycle on.
  assign done     = busy_r && (cnt_r == 4'd15);
  assign div_zero = dz_r;
  assign quotient = dz_r ? '0 : (ovf_r ? PROB_ONE : q_r);

endmodule

// File: rtl/belief_update.sv
// Bayesian belief update for a 2-state POMDP: predict through T, weight by O,
// then normalise with a fixed 16-cycle divider so every update takes 19 cycles.
module belief_update
  import pomdp_pkg::*;
(
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          en_belief,
  input  logic [1:0]                                    action,
  input  logic                                          observation,
  input  prob_t [N_ACT-1:0][N_STATE-1:0][N_OBS-1:0]     observe,
  input  prob_t [N_ACT-1:0][N_STATE-1:0][N_STATE-1:0]   trans,
  input  logic                                          init_en,
  input  prob_t                                         init_b0,
  output prob_t [N_STATE-1:0]                           belief,
  output logic                                          belief_valid,
  output logic                                          busy,
  output logic                                          err
);

  function automatic prob_t mul_q16(input prob_t x, input prob_t y);
    logic [31:0] prod;
    prod = 32'(x) * 32'(y);
    return prob_t'(prod >> 16);
  endfunction

  function automatic prob_t sat16(input logic [16:0] s);
    return s[16] ? PROB_ONE : s[15:0];
  endfunction

  state_t               state_r;
  state_t               state_nxt;
  prob_t [N_STATE-1:0]  b_r;
  prob_t [N_STATE-1:0]  p_nxt;
  prob_t [N_STATE-1:0]  p_p1;
  logic [1:0]           act_p0;
  logic                 obs_p0;
  logic                 err_ill_r;
  prob_t                u0;
  prob_t                u1;
  logic [16:0]          mass;
  logic                 div_start;
  logic                 div_done;
  logic                 div_zero;
  prob_t                q;

  logic idle_start;
  assign idle_start = (state_r == IDLE) && en_belief && !init_en;

  // Stage p0: capture action/observation on the accepted start pulse
  always_ff @(posedge clk) begin
    if (idle_start && (action != 2'd3)) begin
      act_p0 <= action;
      obs_p0 <= observation;
    end
  end

  always_comb begin
    p_nxt = '0;
    for (int sp = 0; sp < N_STATE; sp++)
      p_nxt[sp] = sat16({1'b0, mul_q16(trans[act_p0][0][sp], b_r[0])}
                      + {1'b0, mul_q16(trans[act_p0][1][sp], b_r[1])});
  end

  // Stage p1: predicted state distribution
  always_ff @(posedge clk) begin
    if (state_r == PREDICT)
      p_p1 <= p_nxt;
  end

  // Stage p2: observation weighting; the divider latches u0 and the total mass
  always_comb begin
    u0        = mul_q16(observe[act_p0][0][obs_p0], p_p1[0]);
    u1        = mul_q16(observe[act_p0][1][obs_p0], p_p1[1]);
    mass      = {1'b0, u0} + {1'b0, u1};
    div_start = (state_r == WEIGHT);
  end

  udiv_q16 u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend ({u0, 16'h0000}),
    .divisor  (mass),
    .done     (div_done),
    .quotient (q),
    .div_zero (div_zero)
  );

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE:    if (idle_start && (action != 2'd3)) state_nxt = PREDICT;
      PREDICT: state_nxt = WEIGHT;
      WEIGHT:  state_nxt = DIVIDE;
      DIVIDE:  if (div_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      b_r[0]    <= B0_RST;
      b_r[1]    <= PROB_ONE - B0_RST;
      err_ill_r <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      err_ill_r <= idle_start && (action == 2'd3);
      if ((state_r == IDLE) && init_en) begin
        b_r[0] <= init_b0;
        b_r[1] <= PROB_ONE - init_b0;
      end else if ((state_r == DONE) && !div_zero) begin
        b_r[0] <= q;
        b_r[1] <= PROB_ONE - q;
      end
    end
  end

  assign belief       = b_r;
  assign busy         = (state_r != IDLE);
  assign belief_valid = (state_r == DONE) && !div_zero;
  assign err          = err_ill_r || ((state_r == DONE) && div_zero);

endmodule

// File: tb/tb_belief_update.sv
// Directed self-checking bench for belief_update; cycle numbers count from the capture edge.
module tb_belief_update;
  import pomdp_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     en_belief;
  logic [1:0]               action;
  logic                     observation;
  prob_t [2:0][1:0][1:0]    observe;
  prob_t [2:0][1:0][1:0]    trans;
  logic                     init_en;
  prob_t                    init_b0;
  prob_t [1:0]              belief;
  logic                     belief_valid;
  logic                     busy;
  logic                     err;

  int n_tests = 0;
  int n_fail  = 0;

  belief_update dut (
    .clk          (clk),
    .rst          (rst),
    .en_belief    (en_belief),
    .action       (action),
    .observation  (observation),
    .observe      (observe),
    .trans        (trans),
    .init_en      (init_en),
    .init_b0      (init_b0),
    .belief       (belief),
    .belief_valid (belief_valid),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en_belief = 1'b0; init_en = 1'b0; init_b0 = '0;
    action = '0; observation = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic set_tables(input prob_t tv, input prob_t ov);
    for (int a = 0; a < 3; a++)
      for (int s = 0; s < 2; s++)
        for (int k = 0; k < 2; k++) begin
          trans[a][s][k]   = tv;
          observe[a][s][k] = ov;
        end
  endtask

  // Pulses en_belief in cycle 0 and records outputs over cycles 1..22.
  task automatic run_update(input logic [1:0] a, input logic o, input bit busy_on,
                            output int vcyc, output int vcnt, output int ecyc,
                            output int ecnt, output int busy_bad);
    vcyc = -1; vcnt = 0; ecyc = -1; ecnt = 0; busy_bad = 0;
    en_belief = 1'b1; action = a; observation = o;
    step();
    en_belief = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      if (belief_valid === 1'b1) begin vcnt++; vcyc = c; end
      if (err === 1'b1) begin ecnt++; ecyc = c; end
      if (busy !== (busy_on && c <= 19)) busy_bad++;
      step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (belief[0] !== 16'h8000) begin n_fail++; $display("FAIL reset_b0: got %h want 8000", belief[0]); end
    n_tests++; if (belief[1] !== 16'h7FFF) begin n_fail++; $display("FAIL reset_b1: got %h want 7FFF", belief[1]); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (belief_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", belief_valid); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
  endtask

  task automatic test_uniform();
    int vc, vn, ec, en, bb;
    do_reset();
    set_tables(16'h8000, 16'h8000);
    run_update(2'd2, 1'b0, 1'b1, vc, vn, ec, en, bb);
    n_tests++; if (vc !== 19) begin n_fail++; $display("FAIL uni_valid_cycle: got %0d want 19", vc); end
    n_tests++; if (vn !== 1) begin n_fail++; $display("FAIL uni_valid_count: got %0d want 1", vn); end
    n_tests++; if (en !== 0) begin n_fail++; $display("FAIL uni_err_count: got %0d want 0", en); end
    n_tests++; if (bb !== 0) begin n_fail++; $display("FAIL uni_busy_window: got %0d bad cycles want 0", bb); end
    n_tests++; if (belief[0] !== 16'h8000) begin n_fail++; $display("FAIL uni_b0: got %h want 8000", belief[0]); end
    n_tests++; if (belief[1] !== 16'h7FFF) begin n_fail++; $display("FAIL uni_b1: got %h want 7FFF", belief[1]); end
  endtask

  task automatic test_identity();
    int vc, vn, ec, en, bb;
    do_reset();
    set_tables(16'h0000, 16'h0000);
    for (int a = 0; a < 3; a++) begin
      trans[a][0][0]   = 16'hFFFF;
      trans[a][1][1]   = 16'hFFFF;
      observe[a][0][0] = 16'hC000;
      observe[a][1][0] = 16'h4000;
    end
    run_update(2'd1, 1'b0, 1'b1, vc, vn, ec, en, bb);
    n_tests++; if (vc !== 19) begin n_fail++; $display("FAIL id_valid_cycle: got %0d want 19", vc); end
    n_tests++; if (belief[0] !== 16'hC001) begin n_fail++; $display("FAIL id_b0: got %h want C001", belief[0]); end
    n_tests++; if (belief[1] !== 16'h3FFE) begin n_fail++; $display("FAIL id_b1: got %h want 3FFE", belief[1]); end
  endtask

  // u1 = 0 saturates the quotient to FFFF; then u0 = 0 drives it to 0.
  task automatic test_quotient_edges();
    int vc, vn, ec, en, bb;
    do_reset();
    set_tables(16'h8000, 16'h8000);
    for (int a = 0; a < 3; a++) observe[a][1][1] = 16'h0000;
    run_update(2'd0, 1'b1, 1'b1, vc, vn, ec, en, bb);
    n_tests++; if (belief[0] !== 16'hFFFF) begin n_fail++; $display("FAIL sat_b0: got %h want FFFF", belief[0]); end
    n_tests++; if (belief[1] !== 16'h0000) begin n_fail++; $display("FAIL sat_b1: got %h want 0000", belief[1]); end
    n_tests++; if (vn !== 1) begin n_fail++; $display("FAIL sat_valid_count: got %0d want 1", vn); end
    for (int a = 0; a < 3; a++) observe[a][0][0] = 16'h0000;
    run_update(2'd0, 1'b0, 1'b1, vc, vn, ec, en, bb);
    n_tests++; if (belief[0] !== 16'h0000) begin n_fail++; $display("FAIL zero_q_b0: got %h want 0000", belief[0]); end
    n_tests++; if (belief[1] !== 16'hFFFF) begin n_fail++; $display("FAIL zero_q_b1: got %h want FFFF", belief[1]); end
  endtask

  task automatic test_errors();
    int vc, vn, ec, en, bb;
    do_reset();
    set_tables(16'h8000, 16'h0000);
    run_update(2'd0, 1'b0, 1'b1, vc, vn, ec, en, bb);
    n_tests++; if (vn !== 0) begin n_fail++; $display("FAIL zm_valid_count: got %0d want 0", vn); end
    n_tests++; if (ec !== 19) begin n_fail++; $display("FAIL zm_err_cycle: got %0d want 19", ec); end
    n_tests++; if (en !== 1) begin n_fail++; $display("FAIL zm_err_count: got %0d want 1", en); end
    n_tests++; if (belief[0] !== 16'h8000) begin n_fail++; $display("FAIL zm_b0: got %h want 8000", belief[0]); end
    set_tables(16'h8000, 16'h8000);
    run_update(2'd3, 1'b0, 1'b0, vc, vn, ec, en, bb);
    n_tests++; if (ec !== 1) begin n_fail++; $display("FAIL ill_err_cycle: got %0d want 1", ec); end
    n_tests++; if (en !== 1) begin n_fail++; $display("FAIL ill_err_count: got %0d want 1", en); end
    n_tests++; if (bb !== 0) begin n_fail++; $display("FAIL ill_busy: got %0d busy cycles want 0", bb); end
    n_tests++; if (vn !== 0) begin n_fail++; $display("FAIL ill_valid_count: got %0d want 0", vn); end
    n_tests++; if (belief[1] !== 16'h7FFF) begin n_fail++; $display("FAIL ill_b1: got %h want 7FFF", belief[1]); end
  endtask

  task automatic test_back_to_back();
    int vc = -1, vn = 0, late_busy = 0;
    do_reset();
    set_tables(16'h8000, 16'h8000);
    en_belief = 1'b1; action = 2'd2; observation = 1'b0;
    step();
    for (int c = 1; c <= 24; c++) begin
      if (belief_valid === 1'b1) begin vn++; vc = c; end
      if (c >= 20 && busy !== 1'b0) late_busy++;
      en_belief = (c == 5 || c == 18);
      step();
    end
    en_belief = 1'b0;
    n_tests++; if (vn !== 1) begin n_fail++; $display("FAIL b2b_valid_count: got %0d want 1", vn); end
    n_tests++; if (vc !== 19) begin n_fail++; $display("FAIL b2b_valid_cycle: got %0d want 19", vc); end
    n_tests++; if (late_busy !== 0) begin n_fail++; $display("FAIL b2b_queued: got %0d busy cycles after 19 want 0", late_busy); end
  endtask

  task automatic test_init();
    int bb = 0, ec = -1, en = 0, vn = 0;
    do_reset();
    set_tables(16'h8000, 16'h8000);
    init_en = 1'b1; init_b0 = 16'h1234; en_belief = 1'b1; action = 2'd0;
    step();
    init_en = 1'b0; en_belief = 1'b0;
    n_tests++; if (belief[0] !== 16'h1234) begin n_fail++; $display("FAIL init_b0: got %h want 1234", belief[0]); end
    n_tests++; if (belief[1] !== 16'hEDCB) begin n_fail++; $display("FAIL init_b1: got %h want EDCB", belief[1]); end
    for (int c = 1; c <= 4; c++) begin
      if (busy !== 1'b0) bb++;
      step();
    end
    n_tests++; if (bb !== 0) begin n_fail++; $display("FAIL init_busy: got %0d busy cycles want 0", bb); end
    set_tables(16'h8000, 16'h0000);
    en_belief = 1'b1;
    step();
    en_belief = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      if (err === 1'b1) begin en++; ec = c; end
      if (belief_valid === 1'b1) vn++;
      init_en = (c == 5);
      init_b0 = 16'h0100;
      step();
    end
    init_en = 1'b0;
    n_tests++; if (belief[0] !== 16'h1234) begin n_fail++; $display("FAIL init_busy_b0: got %h want 1234", belief[0]); end
    n_tests++; if (ec !== 19 || en !== 1 || vn !== 0) begin n_fail++; $display("FAIL init_busy_err: err cycle %0d count %0d valid %0d want 19 1 0", ec, en, vn); end
  endtask

  task automatic test_reset_mid();
    int vn = 0, en = 0;
    do_reset();
    set_tables(16'h8000, 16'h8000);
    init_en = 1'b1; init_b0 = 16'h1234;
    step();
    init_en = 1'b0;
    en_belief = 1'b1; action = 2'd2; observation = 1'b0;
    step();
    en_belief = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      if (belief_valid === 1'b1) vn++;
      if (err === 1'b1) en++;
      if (c == 11) begin
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_tests++; if (belief[0] !== 16'h8000) begin n_fail++; $display("FAIL rstmid_b0: got %h want 8000", belief[0]); end
        n_tests++; if (belief[1] !== 16'h7FFF) begin n_fail++; $display("FAIL rstmid_b1: got %h want 7FFF", belief[1]); end
      end
      rst = (c == 10);
      step();
    end
    rst = 1'b0;
    n_tests++; if (vn !== 0 || en !== 0) begin n_fail++; $display("FAIL rstmid_pulses: valid %0d err %0d want 0 0", vn, en); end
  endtask

  initial begin
    rst = 1'b1; en_belief = 1'b0; init_en = 1'b0; init_b0 = '0;
    action = '0; observation = 1'b0;
    observe = '0; trans = '0;
    test_reset();
    test_uniform();
    test_identity();
    test_quotient_edges();
    test_errors();
    test_back_to_back();
    test_init();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
